// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - request/ack and grant bundle between requesters, arbiter and downstream mux
interface rr_mux_arbiter_if #(
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = $clog2(DEPTH)
);
    logic [DEPTH-1:0]     req;
    logic                 ack;
    logic                 grant_valid;
    logic [SEL_WIDTH-1:0] grant_sel;
    logic [DEPTH-1:0]     grant_onehot;
    logic                 timeout_pulse;

    modport master (
        output req, ack,
        input  grant_valid, grant_sel, grant_onehot, timeout_pulse
    );

    modport slave (
        input  req, ack,
        output grant_valid, grant_sel, grant_onehot, timeout_pulse
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter producing a held mux select with ack/timeout release
module rr_mux_arbiter #(
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            rst,
    rr_mux_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic [DEPTH-1:0]     onehot_q, onehot_d;
    logic                 tpulse_q, tpulse_d;

    logic [SEL_WIDTH-1:0] sel_inc;
    logic [SEL_WIDTH-1:0] arb_ptr;
    logic [SEL_WIDTH-1:0] arb_idx;
    logic                 arb_found;

    // Wrap on DEPTH so non-power-of-two requester counts rotate correctly.
    assign sel_inc = (sel_q == SEL_WIDTH'(DEPTH - 1)) ? '0 : sel_q + SEL_WIDTH'(1);
    // While busy, the next grant is arbitrated from the post-ack pointer so back-to-back grants skip the acked requester.
    assign arb_ptr = (state_q == BUSY) ? sel_inc : ptr_q;

    always_comb begin
        int idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = int'(arb_ptr) + k;
            if (idx >= DEPTH) idx = idx - DEPTH;
            if (!arb_found && bus.req[idx]) begin
                arb_found = 1'b1;
                arb_idx   = SEL_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        tpulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = BUSY;
                    sel_d   = arb_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (bus.ack) begin
                    ptr_d = sel_inc;
                    cnt_d = '0;
                    if (arb_found) begin
                        sel_d = arb_idx;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    tpulse_d = 1'b1;
                    ptr_d    = sel_inc;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        onehot_d = valid_d ? (DEPTH'(1) << sel_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            onehot_q <= '0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            tpulse_q <= tpulse_d;
        end
    end

    assign bus.grant_valid   = valid_q;
    assign bus.grant_sel     = sel_q;
    assign bus.grant_onehot  = onehot_q;
    assign bus.timeout_pulse = tpulse_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed and randomized bench for rr_mux_arbiter against a behavioural model
module tb_rr_mux_arbiter;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst;

    rr_mux_arbiter_if #(.DEPTH(DEPTH)) bus ();

    rr_mux_arbiter #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who holds the grant, how long it has been shown, and who goes first next.
    int m_busy = 0;
    int m_sel  = 0;
    int m_ptr  = 0;
    int m_age  = 0;
    int m_tp   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int r, input int p);
        for (int k = 0; k < DEPTH; k++)
            if (r[(p + k) % DEPTH]) return (p + k) % DEPTH;
        return -1;
    endfunction

    task automatic model_edge();
        int r;
        r    = int'(bus.req);
        m_tp = 0;
        if (rst) begin
            m_busy = 0; m_sel = 0; m_ptr = 0; m_age = 0;
        end else if (m_busy == 0) begin
            if (r != 0) begin
                m_sel = pick(r, m_ptr); m_busy = 1; m_age = 1;
            end
        end else if (bus.ack) begin
            m_ptr = (m_sel + 1) % DEPTH;
            if (r != 0) begin
                m_sel = pick(r, m_ptr); m_age = 1;
            end else begin
                m_busy = 0;
            end
        end else if (m_age == TIMEOUT) begin
            m_busy = 0; m_tp = 1; m_ptr = (m_sel + 1) % DEPTH;
        end else begin
            m_age++;
        end
    endtask

    task automatic step();
        int oh;
        @(posedge clk);
        model_edge();
        #1;
        oh = m_busy ? (1 << m_sel) : 0;
        check("grant_valid", 32'(bus.grant_valid), 32'(m_busy));
        check("grant_sel", 32'(bus.grant_sel), 32'(m_sel));
        check("grant_onehot", 32'(bus.grant_onehot), 32'(oh));
        check("timeout_pulse", 32'(bus.timeout_pulse), 32'(m_tp));
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic a);
        rst     = r;
        bus.req = q;
        bus.ack = a;
    endtask

    initial begin
        int tp_seen;
        int lazy;
        drive(1'b1, 4'b0000, 1'b0);
        step();
        check("reset_valid", 32'(bus.grant_valid), 32'd0);
        check("reset_onehot", 32'(bus.grant_onehot), 32'd0);

        drive(1'b0, 4'b1010, 1'b0);
        step();
        check("first_sel", 32'(bus.grant_sel), 32'd1);
        check("first_onehot", 32'(bus.grant_onehot), 32'h2);
        drive(1'b0, 4'b0000, 1'b1);
        step();

        drive(1'b1, 4'b0000, 1'b0);
        step();
        drive(1'b0, 4'b1111, 1'b0);
        step();
        check("rr_sel0", 32'(bus.grant_sel), 32'd0);
        bus.ack = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("rr_seq", 32'(bus.grant_sel), 32'(i % DEPTH));
            check("rr_valid", 32'(bus.grant_valid), 32'd1);
        end

        drive(1'b0, 4'b1000, 1'b1);
        step();
        check("grant3", 32'(bus.grant_sel), 32'd3);
        step();
        check("sole_regrant", 32'(bus.grant_sel), 32'd3);
        check("sole_valid", 32'(bus.grant_valid), 32'd1);
        drive(1'b0, 4'b0000, 1'b1);
        step();

        drive(1'b0, 4'b0100, 1'b0);
        step();
        check("grant2", 32'(bus.grant_sel), 32'd2);
        bus.req = 4'b0000;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        check("hold_valid", 32'(bus.grant_valid), 32'd1);
        step();
        check("to_valid", 32'(bus.grant_valid), 32'd0);
        check("to_pulse", 32'(bus.timeout_pulse), 32'd1);
        bus.req = 4'b0101;
        step();
        check("to_pulse_once", 32'(bus.timeout_pulse), 32'd0);
        check("after_to_sel", 32'(bus.grant_sel), 32'd0);
        drive(1'b0, 4'b0000, 1'b1);
        step();

        drive(1'b0, 4'b0010, 1'b0);
        step();
        bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) step();
        check("sticky_sel", 32'(bus.grant_sel), 32'd1);
        check("sticky_valid", 32'(bus.grant_valid), 32'd1);
        bus.ack = 1'b1;
        step();
        check("ack_idle", 32'(bus.grant_valid), 32'd0);

        drive(1'b0, 4'b0100, 1'b0);
        step();
        check("pre_rst_sel", 32'(bus.grant_sel), 32'd2);
        rst = 1'b1;
        step();
        check("mid_rst_sel", 32'(bus.grant_sel), 32'd0);
        check("mid_rst_valid", 32'(bus.grant_valid), 32'd0);
        tp_seen = 0;
        drive(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            step();
            tp_seen |= int'(bus.timeout_pulse);
        end
        check("rst_no_pulse", 32'(tp_seen), 32'd0);
        bus.req = 4'b1111;
        step();
        check("post_rst_ptr0", 32'(bus.grant_sel), 32'd0);

        // Alternate eager and lazy ack phases so timeouts and back-to-back grants both occur.
        for (int i = 0; i < 4000; i++) begin
            lazy    = (i / 300) % 2;
            rst     = ($urandom_range(0, 249) == 0);
            bus.req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            bus.ack = lazy ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
